// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the memory responder and the processor
// that drives it.
package mem_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 1024;
    localparam int WORD_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        PROC      = 2'b00,
        LD_ACCEPT = 2'b01,
        LD_COMMIT = 2'b10
    } state_e;

endpackage

// File: rtl/mem_word_packer.sv
// Byte-serial to word packer for the program loader: bytes arrive MSB-first and
// word_done pulses for one cycle after the last byte of a word is shifted in.
module mem_word_packer #(
    parameter  int WORD_BYTES = 4,
    localparam int WORD_W     = 8 * WORD_BYTES,
    localparam int BCNT_W     = $clog2(WORD_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic [BCNT_W-1:0] byte_cnt,
    output logic              word_done
);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              word_done_q, word_done_d;

    // Next-state logic for the shift register, byte counter and done strobe
    always_comb begin
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        word_done_d = 1'b0;
        if (clear) begin
            byte_cnt_d = {BCNT_W{1'b0}};
        end else if (shift_en) begin
            word_d = {word_q[WORD_W-9:0], byte_in};
            if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d  = {BCNT_W{1'b0}};
                word_done_d = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Packer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q      <= {WORD_W{1'b0}};
            byte_cnt_q  <= {BCNT_W{1'b0}};
            word_done_q <= 1'b0;
        end else begin
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign word      = word_q;
    assign byte_cnt  = byte_cnt_q;
    assign word_done = word_done_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM behind the processor bus with a one-cycle registered read,
// plus a byte-serial program loader that fills RAM from address 0.
module mem_responder #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DEPTH  = mem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] data_out,
    input  logic              load_mode,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_full,
    output logic              oob
);

    import mem_pkg::*;

    localparam int                MEM_AW     = $clog2(DEPTH);
    localparam int                CNT_W      = ADDR_W + 1;
    localparam int                BCNT_W     = $clog2(DATA_W / 8);
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(DATA_W / 8 - 1);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              ld_ready_q, ld_ready_d;
    logic [CNT_W-1:0]  load_count_q, load_count_d;
    logic              load_full_q, load_full_d;
    logic              oob_q, oob_d;

    logic              in_range_s;
    logic [MEM_AW-1:0] addr_idx_s;
    logic              mem_we_s;
    logic [MEM_AW-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [CNT_W-1:0]  load_count_inc_s;
    logic              pack_clear_s;
    logic              pack_shift_s;
    logic [DATA_W-1:0] pack_word_s;
    logic [BCNT_W-1:0] pack_cnt_s;
    logic              pack_done_s;

    assign in_range_s       = (addr < DEPTH_ADDR);
    assign addr_idx_s       = addr[MEM_AW-1:0];
    assign load_count_inc_s = load_count_q + CNT_ONE;

    mem_word_packer #(
        .WORD_BYTES (DATA_W / 8)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear_s),
        .shift_en  (pack_shift_s),
        .byte_in   (ld_byte),
        .word      (pack_word_s),
        .byte_cnt  (pack_cnt_s),
        .word_done (pack_done_s)
    );

    // FSM next state, RAM write port selection and registered output updates
    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        ld_ready_d   = ld_ready_q;
        load_count_d = load_count_q;
        load_full_d  = load_full_q;
        oob_d        = oob_q;
        mem_we_s     = 1'b0;
        mem_waddr_s  = addr_idx_s;
        mem_wdata_s  = data_in;
        pack_clear_s = 1'b0;
        pack_shift_s = 1'b0;

        case (state_q)
            PROC: begin
                pack_clear_s = 1'b1;
                ld_ready_d   = 1'b0;
                if (load_mode) begin
                    state_d      = LD_ACCEPT;
                    load_count_d = {CNT_W{1'b0}};
                    load_full_d  = 1'b0;
                    ld_ready_d   = 1'b1;
                end else begin
                    // Read uses the pre-write word, so a same-cycle write is read-first
                    if (re) begin
                        if (in_range_s) begin
                            data_out_d = mem[addr_idx_s];
                        end else begin
                            data_out_d = {DATA_W{1'b0}};
                            oob_d      = 1'b1;
                        end
                    end else begin
                        data_out_d = data_out_q;
                    end
                    if (we) begin
                        if (in_range_s) begin
                            mem_we_s = 1'b1;
                        end else begin
                            oob_d = 1'b1;
                        end
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
            end
            LD_ACCEPT: begin
                if (!load_mode) begin
                    state_d    = PROC;
                    ld_ready_d = 1'b0;
                end else begin
                    pack_shift_s = ld_valid & ld_ready_q;
                    if (pack_shift_s && (pack_cnt_s == LAST_BYTE)) begin
                        state_d    = LD_COMMIT;
                        ld_ready_d = 1'b0;
                    end else begin
                        ld_ready_d = !load_full_q;
                    end
                end
            end
            LD_COMMIT: begin
                // The commit completes even if load_mode has just dropped
                mem_we_s     = pack_done_s;
                mem_waddr_s  = load_count_q[MEM_AW-1:0];
                mem_wdata_s  = pack_word_s;
                load_count_d = load_count_inc_s;
                load_full_d  = (load_count_inc_s == DEPTH_CNT);
                if (load_mode) begin
                    state_d    = LD_ACCEPT;
                    ld_ready_d = !(load_count_inc_s == DEPTH_CNT);
                end else begin
                    state_d    = PROC;
                    ld_ready_d = 1'b0;
                end
            end
            default: begin
                state_d    = PROC;
                ld_ready_d = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PROC;
            data_out_q   <= {DATA_W{1'b0}};
            ld_ready_q   <= 1'b0;
            load_count_q <= {CNT_W{1'b0}};
            load_full_q  <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            ld_ready_q   <= ld_ready_d;
            load_count_q <= load_count_d;
            load_full_q  <= load_full_d;
            oob_q        <= oob_d;
        end
    end

    // RAM write port; contents survive reset so loaded programs persist
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign data_out   = data_out_q;
    assign ld_ready   = ld_ready_q;
    assign load_count = load_count_q;
    assign load_full  = load_full_q;
    assign oob        = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a behavioural model is checked against the
// DUT every cycle, alongside hand-computed expectations for each scenario.
module tb_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [31:0] data_in = 32'h0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] data_out;
    logic        load_mode = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_ready;
    logic [16:0] load_count;
    logic        load_full;
    logic        oob;

    int checks = 0;
    int errors = 0;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .data_in    (data_in),
        .we         (we),
        .re         (re),
        .data_out   (data_out),
        .load_mode  (load_mode),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .load_count (load_count),
        .load_full  (load_full),
        .oob        (oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: RAM as an associative array, loader as a byte queue
    logic [31:0] m_mem [int];
    logic [7:0]  m_bytes [$];
    logic [31:0] m_dout;
    bit          m_dout_known;
    bit          m_loading, m_commit, m_ready, m_full, m_oob;
    int          m_count;

    task automatic model_step();
        if (reset) begin
            m_dout = 32'h0; m_dout_known = 1'b1; m_ready = 1'b0; m_count = 0;
            m_full = 1'b0; m_oob = 1'b0; m_loading = 1'b0; m_commit = 1'b0;
            m_bytes.delete();
        end else if (!m_loading) begin
            if (load_mode) begin
                m_loading = 1'b1; m_count = 0; m_full = 1'b0;
                m_commit = 1'b0; m_ready = 1'b1; m_bytes.delete();
            end else begin
                if (re) begin
                    if (int'(addr) < DEPTH) begin
                        m_dout_known = m_mem.exists(int'(addr));
                        if (m_dout_known) m_dout = m_mem[int'(addr)];
                    end else begin
                        m_dout = 32'h0; m_dout_known = 1'b1; m_oob = 1'b1;
                    end
                end
                if (we) begin
                    if (int'(addr) < DEPTH) m_mem[int'(addr)] = data_in;
                    else m_oob = 1'b1;
                end
            end
        end else begin
            if (m_commit) begin
                m_mem[m_count] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_count++;
                m_full = (m_count == DEPTH);
                m_commit = 1'b0;
                m_bytes.delete();
            end else if (load_mode && ld_valid && m_ready) begin
                m_bytes.push_back(ld_byte);
                if (m_bytes.size() == 4) m_commit = 1'b1;
            end
            if (!load_mode) begin
                m_loading = 1'b0;
                m_bytes.delete();
            end
            m_ready = m_loading && !m_commit && !m_full;
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (m_dout_known) chk("cyc_data_out", data_out, m_dout);
            chk("cyc_ld_ready", {31'h0, ld_ready}, {31'h0, m_ready});
            chk("cyc_load_count", {15'h0, load_count}, 32'(m_count));
            chk("cyc_load_full", {31'h0, load_full}, {31'h0, m_full});
            chk("cyc_oob", {31'h0, oob}, {31'h0, m_oob});
        end
    end

    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        re = r; we = w; addr = a; data_in = d;
        @(negedge clk);
    endtask

    // Streams bytes whenever ld_ready is seen high, bounded by a cycle budget
    task automatic feed(input logic [7:0] seq [8], input int n, output logic [15:0] rdy_trace);
        int idx = 0;
        rdy_trace = 16'h0;
        for (int c = 1; c <= 16 && idx < n; c++) begin
            rdy_trace[c-1] = ld_ready;
            if (ld_ready) begin
                ld_valid = 1'b1; ld_byte = seq[idx]; idx++;
            end else begin
                ld_valid = 1'b0;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        chk("feed_bytes_sent", 32'(idx), 32'(n));
    endtask

    logic [7:0]  seq_a [8];
    logic [7:0]  seq_b [8];
    logic [7:0]  seq_c [8];
    logic [15:0] trace;

    initial begin
        seq_a = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        seq_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h00, 8'h00};
        seq_c = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_load_count", {15'h0, load_count}, 32'h0);
        chk("rst_oob", {31'h0, oob}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Basic read of a zeroed word
        step(1'b0, 1'b1, 16'h0000, 32'h0);
        step(1'b1, 1'b0, 16'h0000, 32'h0);
        chk("t1_read0", data_out, 32'h0);
        chk("t1_oob", {31'h0, oob}, 32'h0);
        chk("t1_ld_ready", {31'h0, ld_ready}, 32'h0);

        // Write then read back; data_out holds with re low
        step(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
        step(1'b1, 1'b0, 16'h0010, 32'h0);
        chk("t2_read", data_out, 32'hDEADBEEF);
        step(1'b0, 1'b0, 16'h0020, 32'h0);
        step(1'b0, 1'b0, 16'h0030, 32'h0);
        chk("t2_hold", data_out, 32'hDEADBEEF);

        // Read-first on simultaneous we/re
        step(1'b0, 1'b1, 16'h0005, 32'h1);
        step(1'b1, 1'b1, 16'h0005, 32'h2);
        chk("t3_old_word", data_out, 32'h1);
        step(1'b1, 1'b0, 16'h0005, 32'h0);
        chk("t3_new_word", data_out, 32'h2);

        // Held write: last value wins
        step(1'b0, 1'b1, 16'h0007, 32'hAAAA0001);
        step(1'b0, 1'b1, 16'h0007, 32'hAAAA0002);
        step(1'b0, 1'b1, 16'h0007, 32'hAAAA0003);
        step(1'b1, 1'b0, 16'h0007, 32'h0);
        chk("t3_held_we", data_out, 32'hAAAA0003);

        // Full-rate load of two words
        load_mode = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 32'h0);
        feed(seq_a, 8, trace);
        chk("t4_ready_trace", {16'h0, trace}, 32'h0000_01EF);
        chk("t4_ld_ready_c10", {31'h0, ld_ready}, 32'h0);
        step(1'b0, 1'b0, 16'h0000, 32'h0);
        chk("t4_load_count", {15'h0, load_count}, 32'h2);
        load_mode = 1'b0;
        step(1'b1, 1'b0, 16'h0003, 32'h0);
        chk("t4_ignored_read", data_out, 32'hAAAA0003);
        step(1'b1, 1'b0, 16'h0001, 32'h0);
        chk("t4_mem1", data_out, 32'h9ABCDEF0);
        step(1'b1, 1'b0, 16'h0000, 32'h0);
        chk("t4_mem0", data_out, 32'h12345678);
        chk("t4_count_hold", {15'h0, load_count}, 32'h2);

        // Out-of-range accesses
        step(1'b1, 1'b0, 16'h0400, 32'h0);
        chk("t5_oob_read", data_out, 32'h0);
        chk("t5_oob_flag", {31'h0, oob}, 32'h1);
        step(1'b0, 1'b1, 16'h0400, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 16'h0000, 32'h0);
        chk("t5_no_alias", data_out, 32'h12345678);
        step(1'b0, 1'b0, 16'h0000, 32'h0);
        chk("t5_oob_sticky", {31'h0, oob}, 32'h1);

        // load_mode dropped with a partial word pending
        load_mode = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 32'h0);
        feed(seq_b, 6, trace);
        load_mode = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 32'h0);
        chk("t7_count", {15'h0, load_count}, 32'h1);
        step(1'b1, 1'b0, 16'h0000, 32'h0);
        chk("t7_mem0", data_out, 32'hA1B2C3D4);
        step(1'b1, 1'b0, 16'h0001, 32'h0);
        chk("t7_mem1", data_out, 32'h9ABCDEF0);

        // Reset in the middle of a load
        load_mode = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 32'h0);
        feed(seq_c, 6, trace);
        reset = 1'b1;
        #1;
        chk("t6_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("t6_load_count", {15'h0, load_count}, 32'h0);
        chk("t6_oob", {31'h0, oob}, 32'h0);
        chk("t6_data_out", data_out, 32'h0);
        load_mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 16'h0000, 32'h0);
        chk("t6_mem0", data_out, 32'h11223344);
        step(1'b1, 1'b0, 16'h0001, 32'h0);
        chk("t6_mem1", data_out, 32'h9ABCDEF0);
        step(1'b0, 1'b0, 16'h0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
